// File: rtl/enable_seq_pkg.sv
// enable_seq_pkg: shared state encoding and default widths for the enable sequencer.
package enable_seq_pkg;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_PER_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/period_timer.sv
// period_timer: down-counter that expires once every max(period,1) cycles while running.
module period_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [PER_W-1:0] period_i,
  output logic             expire_o
);
  logic [PER_W-1:0] reload_q, reload_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  // A zero period behaves as one, so the reload value saturates at 0 instead of wrapping.
  always_comb begin
    reload_d = load_i ? ((period_i == '0) ? '0 : period_i - 1'b1) : reload_q;
    cnt_d    = load_i ? reload_d : !run_i ? cnt_q : (cnt_q == '0) ? reload_q : cnt_q - 1'b1;
  end
  assign expire_o = run_i && (cnt_q == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/enable_sequencer.sv
// enable_sequencer: issues cmd_len single-cycle enable strobes spaced by cmd_period,
// then a done pulse; commands arrive over a valid/ready handshake.
module enable_sequencer
  import enable_seq_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pulses_issued
);
  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] pulses_q, pulses_d;
  logic             cmd_ready_q, enable_q, busy_q, done_q;
  logic             accept, running, expire, fire;

  assign accept  = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign running = (state_q == RUN);
  assign fire    = expire && !abort;

  period_timer #(.PER_W(PER_W)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load_i   (accept),
    .run_i    (running),
    .period_i (cmd_period),
    .expire_o (expire)
  );

  // Abort in RUN wins over a coincident expiry and still lands in DONE.
  always_comb begin
    state_d     = (state_q == IDLE) ? (accept ? ((cmd_len == '0) ? DONE : RUN) : IDLE) :
                  running ? ((abort || (fire && remaining_q == LEN_W'(1))) ? DONE : RUN) : IDLE;
    remaining_d = accept ? cmd_len : fire ? remaining_q - 1'b1 : remaining_q;
    pulses_d    = accept ? '0 : fire ? pulses_q + 1'b1 : pulses_q;
  end

  // Status outputs trail the state by one cycle; enable is registered from the expiry itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      pulses_q    <= '0;
      cmd_ready_q <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pulses_q    <= pulses_d;
      cmd_ready_q <= (state_q == IDLE) && !accept;
      enable_q    <= fire;
      busy_q      <= (state_q != IDLE);
      done_q      <= (state_q == DONE);
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign enable        = enable_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pulses_issued = pulses_q;
endmodule

// File: tb/tb_enable_sequencer.sv
// tb_enable_sequencer: directed scenarios for enable_sequencer with cycle-exact expectations.
module tb_enable_sequencer;
  logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] cmd_period = '0;
  logic        cmd_ready, enable, busy, done;
  logic [7:0]  pulses_issued;
  int checks = 0, errors = 0;

  enable_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_period    (cmd_period),
    .abort         (abort),
    .enable        (enable),
    .busy          (busy),
    .done          (done),
    .pulses_issued (pulses_issued)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, presents one command and returns in cycle k.
  task automatic send(input logic [7:0] len, input logic [15:0] per);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got %b expected 1", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_len    = len;
    cmd_period = per;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({enable, done, busy, cmd_ready, pulses_issued} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 000", {enable, done, busy, cmd_ready, pulses_issued});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge got %b expected 0", cmd_ready);
    end
    tick();
    checks++;
    if ({enable, done, busy, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ready_after_edge got %b expected 0001", {enable, done, busy, cmd_ready});
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp;
    send(8'd3, 16'd4);
    checks++;
    if ({enable, done, busy, cmd_ready, pulses_issued} !== 12'h000) begin
      errors++;
      $display("FAIL basic_accept got %h expected 000", {enable, done, busy, cmd_ready, pulses_issued});
    end
    for (int c = 1; c <= 14; c++) begin
      tick();
      exp = {c == 4 || c == 8 || c == 12, c == 13, c <= 13, c == 14};
      checks++;
      if ({enable, done, busy, cmd_ready} !== exp) begin
        errors++;
        $display("FAIL basic c=%0d got %b expected %b", c, {enable, done, busy, cmd_ready}, exp);
      end
    end
    checks++;
    if (pulses_issued !== 8'd3) begin
      errors++;
      $display("FAIL basic_pulses got %0d expected 3", pulses_issued);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    send(8'd5, 16'd0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      exp = {c <= 5, c == 6, c <= 6, c == 7};
      checks++;
      if ({enable, done, busy, cmd_ready} !== exp) begin
        errors++;
        $display("FAIL b2b c=%0d got %b expected %b", c, {enable, done, busy, cmd_ready}, exp);
      end
    end
    checks++;
    if (pulses_issued !== 8'd5) begin
      errors++;
      $display("FAIL b2b_pulses got %0d expected 5", pulses_issued);
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] exp;
    send(8'd0, 16'd7);
    checks++;
    if (pulses_issued !== 8'd0) begin
      errors++;
      $display("FAIL zero_pulses_cleared got %0d expected 0", pulses_issued);
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      exp = {1'b0, c == 1, c == 1, c == 2};
      checks++;
      if ({enable, done, busy, cmd_ready} !== exp) begin
        errors++;
        $display("FAIL zero c=%0d got %b expected %b", c, {enable, done, busy, cmd_ready}, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] exp;
    send(8'd10, 16'd2);
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = {c == 2 || c == 4 || c == 6, c == 9, c <= 9, c == 10};
      checks++;
      if ({enable, done, busy, cmd_ready} !== exp) begin
        errors++;
        $display("FAIL abort c=%0d got %b expected %b", c, {enable, done, busy, cmd_ready}, exp);
      end
      if (c == 9) begin
        checks++;
        if (pulses_issued !== 8'd3) begin
          errors++;
          $display("FAIL abort_pulses got %0d expected 3", pulses_issued);
        end
      end
      abort = (c == 7 || c == 8);
    end
    abort = 1'b0;
  endtask

  task automatic test_handshake();
    logic [3:0] exp;
    logic [7:0] exp_p;
    send(8'd2, 16'd3);
    cmd_valid  = 1'b1;
    cmd_len    = 8'd50;
    cmd_period = 16'd1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      exp = {c == 3 || c == 6 || c == 11, c == 7 || c == 12,
             c <= 7 || (c >= 10 && c <= 12), c == 8 || c == 13};
      checks++;
      if ({enable, done, busy, cmd_ready} !== exp) begin
        errors++;
        $display("FAIL handshake c=%0d got %b expected %b", c, {enable, done, busy, cmd_ready}, exp);
      end
      if (c == 8 || c == 9 || c == 12) begin
        exp_p = (c == 8) ? 8'd2 : (c == 9) ? 8'd0 : 8'd1;
        checks++;
        if (pulses_issued !== exp_p) begin
          errors++;
          $display("FAIL handshake_pulses c=%0d got %0d expected %0d", c, pulses_issued, exp_p);
        end
      end
      cmd_valid  = (c <= 8);
      cmd_len    = (c == 8) ? 8'd1 : 8'(50 + c);
      cmd_period = (c == 8) ? 16'd2 : 16'd1;
      abort      = (c == 8);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    int n_en = 0;
    send(8'd200, 16'd3);
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_en += int'(enable);
    end
    checks++;
    if (n_en != 5 || pulses_issued !== 8'd5) begin
      errors++;
      $display("FAIL rmid_before got enables=%0d pulses=%0d expected 5 and 5", n_en, pulses_issued);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({enable, done, busy, cmd_ready, pulses_issued} !== 12'h000) begin
      errors++;
      $display("FAIL rmid_async got %h expected 000", {enable, done, busy, cmd_ready, pulses_issued});
    end
    tick();
    checks++;
    if ({enable, done, busy, cmd_ready, pulses_issued} !== 12'h000) begin
      errors++;
      $display("FAIL rmid_held got %h expected 000", {enable, done, busy, cmd_ready, pulses_issued});
    end
    #3 reset = 1'b0;
    tick();
    checks++;
    if ({enable, done, busy, cmd_ready, pulses_issued} !== 12'h100) begin
      errors++;
      $display("FAIL rmid_release got %h expected 100", {enable, done, busy, cmd_ready, pulses_issued});
    end
    send(8'd2, 16'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp = {c <= 2, c == 3, 1'b1, 1'b0};
      checks++;
      if ({enable, done, busy, cmd_ready} !== exp) begin
        errors++;
        $display("FAIL rmid_rerun c=%0d got %b expected %b", c, {enable, done, busy, cmd_ready}, exp);
      end
    end
    checks++;
    if (pulses_issued !== 8'd2) begin
      errors++;
      $display("FAIL rmid_pulses got %0d expected 2", pulses_issued);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_len();
    test_abort();
    test_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
